conv_pass_sequencer: RTL

- Executes one convolution layer for the systolic array (STA) on the STA-controller side.
- Takes the per-layer parameters and start pulse from the layer controller and walks the loop nest: output-channel tile, output row, output column, kernel row, kernel column, input channel.
- Emits one window beat per step to the input/weight fetch logic over a valid/ready handshake.
- Raises `sta_idle` once the array has drained, which lets the layer controller advance.

---
 rtl/conv_pass_sequencer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv_pass_sequencer.sv
// Convolution loop-nest sequencer: one fetch window beat per step; optional CONV_SEQ_PERF_EN adds beat/stall counters.
// First beat 2 cycles after layer_start, then one beat per cycle; all beat outputs hold while win_valid && !win_ready.
`timescale 1ns/1ps
module conv_pass_sequencer #(
   parameter int SA_N = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            layer_start,
   input  logic [15:0]     mat_size,
   input  logic [15:0]     in_ch,
   input  logic [15:0]     out_ch,
   input  logic [15:0]     kernel_h,
   input  logic [15:0]     kernel_w,
   input  logic [15:0]     stride_h,
   input  logic [15:0]     stride_w,
   input  logic            sta_drained,
   output logic            win_valid,
   input  logic            win_ready,
   output logic [15:0]     win_row,
   output logic [15:0]     win_col,
   output logic [15:0]     win_ic,
   output logic [15:0]     win_oc_base,
   output logic [SA_N-1:0] win_oc_mask,
   output logic            win_acc_first,
   output logic            win_acc_last,
   output logic            sta_idle,
   output logic            done,
   output logic            err
`ifdef CONV_SEQ_PERF_EN
   ,
   output logic [31:0]     perf_beats,
   output logic [31:0]     perf_stall
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]  state;
   logic [15:0] p_mat, p_in_ch, p_out_ch, p_kh, p_kw, p_sh, p_sw;
   logic [15:0] ic, kc, kr, c0, r0, oc_base;

   logic ic_last, kc_last, kr_last, c0_more, r0_more, oc_more;
   logic adv, final_beat, load_beat, params_bad, accept;
   logic [15:0] n_ic, n_kc, n_kr, n_c0, n_r0, n_oc;
   logic n_first, n_last;
   logic [SA_N-1:0] n_mask;

   assign accept = (state == S_IDLE) && layer_start;

   // Bound sums carry an extra bit so large parameters cannot wrap.
   always_comb begin
      ic_last    = ({1'b0, ic} + 17'd1) == {1'b0, p_in_ch};
      kc_last    = ({1'b0, kc} + 17'd1) == {1'b0, p_kw};
      kr_last    = ({1'b0, kr} + 17'd1) == {1'b0, p_kh};
      c0_more    = ({1'b0, c0} + {1'b0, p_sw} + {1'b0, p_kw}) <= {1'b0, p_mat};
      r0_more    = ({1'b0, r0} + {1'b0, p_sh} + {1'b0, p_kh}) <= {1'b0, p_mat};
      oc_more    = ({1'b0, oc_base} + 17'(SA_N)) < {1'b0, p_out_ch};
      adv        = (state == S_ISSUE) && win_valid && win_ready;
      final_beat = ic_last && kc_last && kr_last && !c0_more && !r0_more && !oc_more;
      params_bad = (p_kh > p_mat) || (p_kw > p_mat) || (p_in_ch == 16'd0) ||
                   (p_out_ch == 16'd0) || (p_kh == 16'd0) || (p_kw == 16'd0) ||
                   (p_sh == 16'd0) || (p_sw == 16'd0);
      load_beat  = ((state == S_CHECK) && !params_bad) || (adv && !final_beat);
   end

   // Counter cascade: innermost ic first, carrying out to oc_base.
   always_comb begin
      n_ic = ic;
      n_kc = kc;
      n_kr = kr;
      n_c0 = c0;
      n_r0 = r0;
      n_oc = oc_base;
      if (adv) begin
         n_ic = ic_last ? 16'd0 : ic + 16'd1;
         if (ic_last) begin
            n_kc = kc_last ? 16'd0 : kc + 16'd1;
            if (kc_last) begin
               n_kr = kr_last ? 16'd0 : kr + 16'd1;
               if (kr_last) begin
                  n_c0 = c0_more ? c0 + p_sw : 16'd0;
                  if (!c0_more) begin
                     n_r0 = r0_more ? r0 + p_sh : 16'd0;
                     if (!r0_more && oc_more) begin
                        n_oc = oc_base + 16'(SA_N);
                     end
                  end
               end
            end
         end
      end
   end

   always_comb begin
      n_mask  = '0;
      n_first = (n_ic == 16'd0) && (n_kc == 16'd0) && (n_kr == 16'd0);
      n_last  = (({1'b0, n_ic} + 17'd1) == {1'b0, p_in_ch}) &&
                (({1'b0, n_kc} + 17'd1) == {1'b0, p_kw}) &&
                (({1'b0, n_kr} + 17'd1) == {1'b0, p_kh});
      for (int i = 0; i < SA_N; i++) begin
         n_mask[i] = ({1'b0, n_oc} + 17'(i)) < {1'b0, p_out_ch};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         sta_idle  <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         win_valid <= 1'b0;
         p_mat     <= '0;
         p_in_ch   <= '0;
         p_out_ch  <= '0;
         p_kh      <= '0;
         p_kw      <= '0;
         p_sh      <= '0;
         p_sw      <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (layer_start) begin
                  p_mat    <= mat_size;
                  p_in_ch  <= in_ch;
                  p_out_ch <= out_ch;
                  p_kh     <= kernel_h;
                  p_kw     <= kernel_w;
                  p_sh     <= stride_h;
                  p_sw     <= stride_w;
                  sta_idle <= 1'b0;
                  state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (params_bad) begin
                  err      <= 1'b1;
                  sta_idle <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  win_valid <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (adv && final_beat) begin
                  win_valid <= 1'b0;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (sta_drained) begin
                  done     <= 1'b1;
                  sta_idle <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               win_valid <= 1'b0;
               sta_idle  <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ic            <= '0;
         kc            <= '0;
         kr            <= '0;
         c0            <= '0;
         r0            <= '0;
         oc_base       <= '0;
         win_row       <= '0;
         win_col       <= '0;
         win_ic        <= '0;
         win_oc_base   <= '0;
         win_oc_mask   <= '0;
         win_acc_first <= 1'b0;
         win_acc_last  <= 1'b0;
      end else if (accept) begin
         ic      <= '0;
         kc      <= '0;
         kr      <= '0;
         c0      <= '0;
         r0      <= '0;
         oc_base <= '0;
      end else if (load_beat) begin
         ic            <= n_ic;
         kc            <= n_kc;
         kr            <= n_kr;
         c0            <= n_c0;
         r0            <= n_r0;
         oc_base       <= n_oc;
         win_row       <= n_r0 + n_kr;
         win_col       <= n_c0 + n_kc;
         win_ic        <= n_ic;
         win_oc_base   <= n_oc;
         win_oc_mask   <= n_mask;
         win_acc_first <= n_first;
         win_acc_last  <= n_last;
      end
   end

`ifdef CONV_SEQ_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_beats <= '0;
         perf_stall <= '0;
      end else if (accept) begin
         perf_beats <= '0;
         perf_stall <= '0;
      end else begin
         if (win_valid && win_ready && (perf_beats != 32'hFFFF_FFFF)) begin
            perf_beats <= perf_beats + 32'd1;
         end
         if (win_valid && !win_ready && (perf_stall != 32'hFFFF_FFFF)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule
